// File: rtl/sgm_disparity_pipeline_pkg.sv
// sgm_disparity_pipeline_pkg: shared SGM default widths, saturation limits and index-width helper
package sgm_disparity_pipeline_pkg;
  localparam int DEF_DISPARITY_RANGE = 64;
  localparam int DEF_COST_BITS = 8;
  localparam int DEF_ACC_COST_BITS = 10;
  localparam int COST_MAX = (1 << DEF_COST_BITS) - 1;
  localparam int ACC_MAX = (1 << DEF_ACC_COST_BITS) - 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sgm_path_aggregator.sv
// sgm_path_aggregator: left-to-right SGM path cost recurrence with P1/P2 penalties, min-normalisation and saturation
module sgm_path_aggregator
  import sgm_disparity_pipeline_pkg::*;
#(
  parameter int DISPARITY_RANGE = DEF_DISPARITY_RANGE,
  parameter int COST_BITS = DEF_COST_BITS,
  parameter int ACC_COST_BITS = DEF_ACC_COST_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  input  logic [COST_BITS-1:0] p1,
  input  logic [COST_BITS-1:0] p2,
  input  logic [DISPARITY_RANGE-1:0][COST_BITS-1:0] cost,
  output logic [DISPARITY_RANGE-1:0][ACC_COST_BITS-1:0] path
);
  localparam int DR = DISPARITY_RANGE;
  localparam int W = ACC_COST_BITS + 1;
  localparam logic [W-1:0] WMAX = W'((1 << ACC_COST_BITS) - 1);
  logic [DR-1:0][ACC_COST_BITS-1:0] l_q, l_d;
  logic [W-1:0] ext [DR+2];
  logic [W-1:0] min_lp, pen1, pen2, lo, hi, m, s;
  always_comb begin
    ext[0] = WMAX;
    ext[DR+1] = WMAX;
    min_lp = WMAX;
    for (int i = 0; i < DR; i++) begin
      ext[i+1] = W'(l_q[i]);
      min_lp = W'(l_q[i]) < min_lp ? W'(l_q[i]) : min_lp;
    end
    pen1 = W'(p1);
    pen2 = min_lp + (p2 > p1 ? W'(p2) : W'(p1));
    lo = '0;
    hi = '0;
    m = '0;
    s = '0;
    l_d = l_q;
    for (int i = 0; i < DR; i++) begin
      lo = ext[i] + pen1;
      hi = ext[i+2] + pen1;
      m = ext[i+1];
      m = lo < m ? lo : m;
      m = hi < m ? hi : m;
      m = pen2 < m ? pen2 : m;
      s = W'(cost[i]) + m - min_lp;
      l_d[i] = !en ? l_q[i] : restart ? ACC_COST_BITS'(cost[i]) : s > WMAX ? WMAX[ACC_COST_BITS-1:0] : s[ACC_COST_BITS-1:0];
    end
  end
  always_ff @(posedge clk) l_q <= rst ? '0 : l_d;
  assign path = l_q;
endmodule

// File: rtl/sgm_disparity_pipeline.sv
// sgm_disparity_pipeline: 3-stage SGM disparity core (AD cost, path aggregation, argmin); SGM_COST_THRESHOLD_EN zeroes disparity when min_cost > cost_threshold
module sgm_disparity_pipeline
  import sgm_disparity_pipeline_pkg::*;
#(
  parameter int DISPARITY_RANGE = DEF_DISPARITY_RANGE,
  parameter int PIXEL_BITS = 8,
  parameter int COST_BITS = DEF_COST_BITS,
  parameter int ACC_COST_BITS = DEF_ACC_COST_BITS,
  parameter int COL_BITS = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic de_in,
  input  logic h_sync_in,
  input  logic v_sync_in,
  input  logic [PIXEL_BITS-1:0] pixel_left,
  input  logic [PIXEL_BITS-1:0] pixel_right,
  input  logic [COST_BITS-1:0] p1,
  input  logic [COST_BITS-1:0] p2,
  input  logic [ACC_COST_BITS-1:0] cost_threshold,
  output logic clk_out,
  output logic de_out,
  output logic h_sync_out,
  output logic v_sync_out,
  output logic [7:0] pixel_disparity,
  output logic [ACC_COST_BITS-1:0] min_cost
);
  localparam int DR = DISPARITY_RANGE;
  localparam int IW = clog2(DR);
  localparam logic [COST_BITS-1:0] CMAX = '1;
  logic [DR-2:0][PIXEL_BITS-1:0] sr_q, sr_d;
  logic [DR-1:0][PIXEL_BITS-1:0] rt;
  logic [DR-1:0][COST_BITS-1:0] c_q, c_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic restart_q, restart_d;
  logic [2:0] de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [DR-1:0][ACC_COST_BITS-1:0] path;
  logic [PIXEL_BITS-1:0] diff;
  logic [IW-1:0] idx;
  logic [ACC_COST_BITS-1:0] best, min_q, min_d;
  logic [7:0] sel, disp_q, disp_d;
  always_comb begin
    rt[0] = pixel_right;
    for (int i = 1; i < DR; i++) rt[i] = sr_q[i-1];
    sr_d = sr_q;
    for (int i = 0; i < DR - 1; i++) sr_d[i] = de_in ? rt[i] : sr_q[i];
    col_d = de_in ? (&col_q ? col_q : col_q + COL_BITS'(1)) : '0;
    restart_d = de_in && col_q == '0;
    de_d = {de_q[1:0], de_in};
    hs_d = {hs_q[1:0], h_sync_in};
    vs_d = {vs_q[1:0], v_sync_in};
    diff = '0;
    c_d = c_q;
    for (int i = 0; i < DR; i++) begin
      diff = pixel_left > rt[i] ? pixel_left - rt[i] : rt[i] - pixel_left;
      c_d[i] = i > int'(col_q) ? CMAX : 32'(diff) > 32'(CMAX) ? CMAX : COST_BITS'(diff);
    end
  end
  sgm_path_aggregator #(
    .DISPARITY_RANGE(DISPARITY_RANGE),
    .COST_BITS(COST_BITS),
    .ACC_COST_BITS(ACC_COST_BITS)
  ) u_agg (
    .clk(clk),
    .rst(rst),
    .en(de_q[0]),
    .restart(restart_q),
    .p1(p1),
    .p2(p2),
    .cost(c_q),
    .path(path)
  );
  always_comb begin
    best = path[0];
    idx = '0;
    for (int i = 1; i < DR; i++) begin
      idx = path[i] < best ? IW'(i) : idx;
      best = path[i] < best ? path[i] : best;
    end
`ifdef SGM_COST_THRESHOLD_EN
    sel = best > cost_threshold ? 8'd0 : 8'(idx);
`else
    sel = 8'(idx);
`endif
    disp_d = de_q[1] ? sel : disp_q;
    min_d = de_q[1] ? best : min_q;
  end
`ifndef SGM_COST_THRESHOLD_EN
  logic unused_thr;
  assign unused_thr = ^cost_threshold;
`endif
  always_ff @(posedge clk) begin
    sr_q <= rst ? '0 : sr_d;
    col_q <= rst ? '0 : col_d;
    c_q <= rst ? '0 : c_d;
    restart_q <= rst ? 1'b0 : restart_d;
    de_q <= rst ? '0 : de_d;
    hs_q <= rst ? '0 : hs_d;
    vs_q <= rst ? '0 : vs_d;
    disp_q <= rst ? '0 : disp_d;
    min_q <= rst ? '0 : min_d;
  end
  assign clk_out = clk;
  assign de_out = de_q[2];
  assign h_sync_out = hs_q[2];
  assign v_sync_out = vs_q[2];
  assign pixel_disparity = disp_q;
  assign min_cost = min_q;
endmodule
